uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Bus between four byte requesters / one UART transmitter (master side) and
// the arbiter (slave side).
interface uart_tx_arbiter_if;
  // Handshake: requester i holds req_valid[i], its req_data byte and req_last[i]
  // stable until a one-cycle req_ready[i] pulse; that pulse is the acceptance.
  // The arbiter pulses tx_start with tx_data valid; the transmitter answers with
  // one tx_done pulse per frame and keeps tx_busy high while it cannot start one.
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        tx_done;
  logic        tx_err;

  modport master (
    output req_valid, req_data, req_last, tx_busy, tx_done,
    input  req_ready, grant, tx_data, tx_start, tx_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy, tx_done,
    output req_ready, grant, tx_data, tx_start, tx_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters,
// with bounded bursts per grant and a transmit-done timeout.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus,
  output logic [1:0]         state_o,
  output logic [1:0]         rr_ptr_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam logic [3:0]  MAX_B   = 4'(MAX_BURST);
  // Registered tx_err lands the cycle the counter reaches TIMEOUT-1 (TIMEOUT >= 2).
  localparam logic [15:0] TO_LAST = TIMEOUT - 16'd2;

  state_t      state_q;
  logic [1:0]  rr_ptr_q;
  logic [1:0]  owner_q;
  logic [3:0]  grant_q;
  logic [3:0]  req_ready_q;
  logic        tx_start_q;
  logic        tx_err_q;
  logic [7:0]  tx_data_q;
  logic        last_q;
  logic [3:0]  burst_q;
  logic [15:0] cnt_q;

  logic [3:0]  burst_d;
  logic [15:0] cnt_d;
  logic [1:0]  cand;
  logic [1:0]  win_idx;
  logic        win_found;
  logic [3:0]  win_oh;
  logic [3:0]  owner_oh;
  logic [7:0]  win_byte;
  logic [7:0]  owner_byte;
  logic        cont_ok;
  logic        timeout_hit;

  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_oh      = 4'b0001 << win_idx;
  assign owner_oh    = 4'b0001 << owner_q;
  assign win_byte    = bus.req_data[{win_idx, 3'b000} +: 8];
  assign owner_byte  = bus.req_data[{owner_q, 3'b000} +: 8];
  assign burst_d     = burst_q + 4'd1;
  assign cnt_d       = cnt_q + 16'd1;
  assign cont_ok     = bus.req_valid[owner_q] && !last_q && (burst_q < MAX_B);
  assign timeout_hit = (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      owner_q     <= 2'd0;
      grant_q     <= 4'd0;
      req_ready_q <= 4'd0;
      tx_start_q  <= 1'b0;
      tx_err_q    <= 1'b0;
      tx_data_q   <= 8'h00;
      last_q      <= 1'b0;
      burst_q     <= 4'd0;
      cnt_q       <= 16'd0;
    end else begin
      tx_start_q  <= 1'b0;
      req_ready_q <= 4'd0;
      tx_err_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found && !bus.tx_busy) begin
            owner_q     <= win_idx;
            grant_q     <= win_oh;
            tx_data_q   <= win_byte;
            tx_start_q  <= 1'b1;
            req_ready_q <= win_oh;
            state_q     <= SEND;
          end else begin
            grant_q <= 4'd0;
          end
        end
        SEND: begin
          last_q  <= bus.req_last[owner_q];
          burst_q <= burst_d;
          cnt_q   <= 16'd0;
          state_q <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (bus.tx_done && cont_ok) begin
            tx_data_q   <= owner_byte;
            tx_start_q  <= 1'b1;
            req_ready_q <= owner_oh;
            state_q     <= SEND;
          end else if (bus.tx_done || timeout_hit) begin
            // tx_done beats a simultaneous timeout.
            tx_err_q <= !bus.tx_done;
            grant_q  <= 4'd0;
            rr_ptr_q <= owner_q + 2'd1;
            burst_q  <= 4'd0;
            state_q  <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_err    = tx_err_q;
  assign state_o       = state_q;
  assign rr_ptr_o      = rr_ptr_q;

endmodule
